// File: rtl/hart_sched.sv
// hart_sched: per-hart thread state tracker and round-robin fetch selector
// for a 4-hart barrel pipeline.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous active-high reset
//   stall               freezes issue selection (state updates continue)
//   hstart/hs_id        start request for an IDLE hart
//   hkill/hk_id         kill request, any state -> IDLE
//   cache_miss/cm_hart_id   I-cache miss, ACTIVE -> PEND
//   refill_done/rf_hart_id  refill complete, PEND -> ACTIVE
//   hart_id, issue_en   registered fetch selection and its valid flag
//   hidle, hpend        per-hart IDLE / PEND flags from registered state
//   hs_idle             combinational hidle[hs_id]
//   active_cnt          number of ACTIVE harts
module hart_sched #(
    parameter int HART_NUM  = 4,
    parameter int HART_ID_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 hstart,
    input  logic [HART_ID_W-1:0] hs_id,
    input  logic                 hkill,
    input  logic [HART_ID_W-1:0] hk_id,
    input  logic                 cache_miss,
    input  logic [HART_ID_W-1:0] cm_hart_id,
    input  logic                 refill_done,
    input  logic [HART_ID_W-1:0] rf_hart_id,
    output logic [HART_ID_W-1:0] hart_id,
    output logic                 issue_en,
    output logic [HART_NUM-1:0]  hidle,
    output logic [HART_NUM-1:0]  hpend,
    output logic                 hs_idle,
    output logic [HART_ID_W:0]   active_cnt
);

    typedef enum logic [1:0] {
        H_IDLE   = 2'b00,
        H_ACTIVE = 2'b01,
        H_PEND   = 2'b10
    } hstate_e;

    hstate_e              state_q [HART_NUM];
    hstate_e              state_d [HART_NUM];
    logic [HART_ID_W-1:0] hart_id_q, hart_id_d;
    logic                 issue_en_q, issue_en_d;
    logic [HART_NUM-1:0]  elig;
    logic [HART_NUM-1:0]  is_idle;
    logic [HART_ID_W-1:0] cand;
    logic                 found;
    logic [HART_ID_W:0]   cnt;

    // Unreachable encoding 2'b11 is treated as IDLE everywhere.
    always_comb begin
        for (int unsigned i = 0; i < HART_NUM; i++) begin
            is_idle[i] = (state_q[i] != H_ACTIVE) && (state_q[i] != H_PEND);
        end
    end

    // Per-hart next state; kill > miss > refill > start. Each lower-priority
    // request also requires its own source state, so it is simply ignored
    // when it does not match.
    always_comb begin
        for (int unsigned i = 0; i < HART_NUM; i++) begin
            state_d[i] = state_q[i];
            if (hkill && hk_id == HART_ID_W'(i)) begin
                state_d[i] = H_IDLE;
            end else if (cache_miss && cm_hart_id == HART_ID_W'(i) &&
                         state_q[i] == H_ACTIVE) begin
                state_d[i] = H_PEND;
            end else if (refill_done && rf_hart_id == HART_ID_W'(i) &&
                         state_q[i] == H_PEND) begin
                state_d[i] = H_ACTIVE;
            end else if (hstart && hs_id == HART_ID_W'(i) && is_idle[i]) begin
                state_d[i] = H_ACTIVE;
            end
        end
    end

    // A hart leaving ACTIVE this cycle must not be picked for the next slot.
    always_comb begin
        for (int unsigned i = 0; i < HART_NUM; i++) begin
            elig[i] = (state_q[i] == H_ACTIVE) &&
                      !(cache_miss && cm_hart_id == HART_ID_W'(i)) &&
                      !(hkill && hk_id == HART_ID_W'(i));
        end
    end

    // Round-robin scan cur+1 .. cur+HART_NUM; the last offset wraps to cur
    // itself so a lone eligible hart is reselected every cycle.
    always_comb begin
        hart_id_d  = hart_id_q;
        issue_en_d = issue_en_q;
        found      = 1'b0;
        cand       = '0;
        if (!stall) begin
            issue_en_d = 1'b0;
            for (int unsigned k = 1; k <= HART_NUM; k++) begin
                cand = hart_id_q + HART_ID_W'(k);
                if (!found && elig[cand]) begin
                    found      = 1'b1;
                    hart_id_d  = cand;
                    issue_en_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < HART_NUM; i++) begin
                state_q[i] <= (i == 0) ? H_ACTIVE : H_IDLE;
            end
            hart_id_q  <= '0;
            issue_en_q <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < HART_NUM; i++) begin
                state_q[i] <= state_d[i];
            end
            hart_id_q  <= hart_id_d;
            issue_en_q <= issue_en_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < HART_NUM; i++) begin
            hpend[i] = (state_q[i] == H_PEND);
            cnt      = cnt + (HART_ID_W+1)'(state_q[i] == H_ACTIVE);
        end
    end

    assign hidle      = is_idle;
    assign hs_idle    = is_idle[hs_id];
    assign active_cnt = cnt;
    assign hart_id    = hart_id_q;
    assign issue_en   = issue_en_q;

endmodule

// File: tb/tb_hart_sched.sv
// Directed bench for hart_sched. The driver pushes a hand-computed expected
// post-edge snapshot for every cycle it drives; the monitor pops one entry
// after each rising edge and compares it against the DUT outputs.
module tb_hart_sched;

    logic       clk = 1'b0;
    logic       reset, stall, hstart, hkill, cache_miss, refill_done;
    logic [1:0] hs_id, hk_id, cm_hart_id, rf_hart_id;
    logic [1:0] hart_id;
    logic       issue_en;
    logic [3:0] hidle, hpend;
    logic       hs_idle;
    logic [2:0] active_cnt;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct {
        logic [1:0] hid;
        logic       ien;
        logic [3:0] idle;
        logic [3:0] pend;
        logic [2:0] cnt;
        logic [1:0] hsid;
        int         step;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hart_sched #(.HART_NUM(4), .HART_ID_W(2)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .hstart(hstart), .hs_id(hs_id),
        .hkill(hkill), .hk_id(hk_id),
        .cache_miss(cache_miss), .cm_hart_id(cm_hart_id),
        .refill_done(refill_done), .rf_hart_id(rf_hart_id),
        .hart_id(hart_id), .issue_en(issue_en),
        .hidle(hidle), .hpend(hpend), .hs_idle(hs_idle),
        .active_cnt(active_cnt)
    );

    task automatic chk(input string name, input int step,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", name, step, act, exp);
        end
    endtask

    // Monitor: one expected snapshot per driven edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("hart_id",    e.step, {6'd0, hart_id},    {6'd0, e.hid});
                chk("issue_en",   e.step, {7'd0, issue_en},   {7'd0, e.ien});
                chk("hidle",      e.step, {4'd0, hidle},      {4'd0, e.idle});
                chk("hpend",      e.step, {4'd0, hpend},      {4'd0, e.pend});
                chk("active_cnt", e.step, {5'd0, active_cnt}, {5'd0, e.cnt});
                chk("hs_idle",    e.step, {7'd0, hs_idle},    {7'd0, e.idle[e.hsid]});
            end
        end
    end

    task automatic clear_inputs();
        reset = 0; stall = 0; hstart = 0; hkill = 0; cache_miss = 0; refill_done = 0;
        hs_id = 0; hk_id = 0; cm_hart_id = 0; rf_hart_id = 0;
    endtask

    // Inputs already set by the caller; queue the expectation for this edge.
    task automatic cyc(input logic [1:0] hid, input logic ien, input logic [3:0] idle,
                       input logic [3:0] pend, input logic [2:0] cnt);
        exp_t e;
        e.hid = hid; e.ien = ien; e.idle = idle; e.pend = pend; e.cnt = cnt;
        e.hsid = hs_id; e.step = step_no;
        sb.push_back(e);
        step_no++;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clk);

        // Reset state
        reset = 1;                                   cyc(0, 1, 4'b1110, 4'b0000, 1);
        reset = 1; stall = 1; hstart = 1; hs_id = 2; cyc(0, 1, 4'b1110, 4'b0000, 1);

        // Start harts 1..3, then rotation
        hstart = 1; hs_id = 1;                       cyc(0, 1, 4'b1100, 4'b0000, 2);
        hstart = 1; hs_id = 2;                       cyc(1, 1, 4'b1000, 4'b0000, 3);
        hstart = 1; hs_id = 3;                       cyc(2, 1, 4'b0000, 4'b0000, 4);
        cyc(3, 1, 4'b0000, 4'b0000, 4);
        cyc(0, 1, 4'b0000, 4'b0000, 4);
        cyc(1, 1, 4'b0000, 4'b0000, 4);

        // Miss on hart 2 while hart_id=1: skip it until refill
        cache_miss = 1; cm_hart_id = 2;              cyc(3, 1, 4'b0000, 4'b0100, 3);
        cyc(0, 1, 4'b0000, 4'b0100, 3);
        cyc(1, 1, 4'b0000, 4'b0100, 3);
        cyc(3, 1, 4'b0000, 4'b0100, 3);
        refill_done = 1; rf_hart_id = 2;             cyc(0, 1, 4'b0000, 4'b0000, 4);
        cyc(1, 1, 4'b0000, 4'b0000, 4);
        cyc(2, 1, 4'b0000, 4'b0000, 4);
        cyc(3, 1, 4'b0000, 4'b0000, 4);

        // Kill + miss + start on hart 2 in the same cycle: kill wins
        hkill = 1; hk_id = 2; cache_miss = 1; cm_hart_id = 2; hstart = 1; hs_id = 2;
        cyc(0, 1, 4'b0100, 4'b0000, 3);
        cyc(1, 1, 4'b0100, 4'b0000, 3);
        cyc(3, 1, 4'b0100, 4'b0000, 3);

        // Kill hart 3, then start it under a 3-cycle stall
        hkill = 1; hk_id = 3;                        cyc(0, 1, 4'b1100, 4'b0000, 2);
        stall = 1; hstart = 1; hs_id = 3;            cyc(0, 1, 4'b0100, 4'b0000, 3);
        stall = 1; hstart = 1; hs_id = 3;            cyc(0, 1, 4'b0100, 4'b0000, 3);
        stall = 1; hstart = 1; hs_id = 3;            cyc(0, 1, 4'b0100, 4'b0000, 3);
        cyc(1, 1, 4'b0100, 4'b0000, 3);
        cyc(3, 1, 4'b0100, 4'b0000, 3);
        cyc(0, 1, 4'b0100, 4'b0000, 3);

        // Reduce to hart 0 only; single hart reselected
        hkill = 1; hk_id = 1;                        cyc(3, 1, 4'b0110, 4'b0000, 2);
        hkill = 1; hk_id = 3;                        cyc(0, 1, 4'b1110, 4'b0000, 1);
        cyc(0, 1, 4'b1110, 4'b0000, 1);

        // Miss on the only active hart: issue_en drops, hart_id holds
        cache_miss = 1; cm_hart_id = 0;              cyc(0, 0, 4'b1110, 4'b0001, 0);
        cyc(0, 0, 4'b1110, 4'b0001, 0);
        stall = 1;                                   cyc(0, 0, 4'b1110, 4'b0001, 0);
        refill_done = 1; rf_hart_id = 0;             cyc(0, 0, 4'b1110, 4'b0000, 1);
        cyc(0, 1, 4'b1110, 4'b0000, 1);

        // Mismatched requests are ignored
        hstart = 1; hs_id = 0; refill_done = 1; rf_hart_id = 1; cache_miss = 1; cm_hart_id = 2;
        cyc(0, 1, 4'b1110, 4'b0000, 1);

        // Events on different harts in one cycle all apply
        hstart = 1; hs_id = 1; cache_miss = 1; cm_hart_id = 0;
        cyc(0, 0, 4'b1100, 4'b0001, 1);
        refill_done = 1; rf_hart_id = 0; hstart = 1; hs_id = 2; cache_miss = 1; cm_hart_id = 1;
        cyc(0, 0, 4'b1000, 4'b0010, 2);
        cache_miss = 1; cm_hart_id = 2;              cyc(0, 1, 4'b1000, 4'b0110, 1);
        hstart = 1; hs_id = 3;                       cyc(0, 1, 4'b0000, 4'b0110, 2);
        cyc(3, 1, 4'b0000, 4'b0110, 2);

        // Reset with harts 1,2 PEND and hart_id=3 overrides everything
        reset = 1; stall = 1; hstart = 1; hs_id = 1; cache_miss = 1; cm_hart_id = 0;
        refill_done = 1; rf_hart_id = 1;
        cyc(0, 1, 4'b1110, 4'b0000, 1);
        cyc(0, 1, 4'b1110, 4'b0000, 1);

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
